// File: rtl/irq_conditioner.sv
// irq_conditioner: synchronise, debounce and edge-detect raw inputs into
// acknowledge-cleared pending interrupt requests with sticky lost-edge flags.
module irq_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         raw_in,
   input  logic                     ack_valid,
   input  logic [$clog2(WIDTH)-1:0] ack_id,
   input  logic                     ovf_clear,
   output logic [WIDTH-1:0]         irq_out,
   output logic [WIDTH-1:0]         stable_out,
   output logic [WIDTH-1:0]         overflow
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [WIDTH-1:0] s1_q, s2_q, stable_q, stable_d, stable_dly_q;
   logic [WIDTH-1:0] pend_q, pend_d, ovf_q, ovf_d, rise, ack_hit;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   always_comb begin
      rise     = stable_q & ~stable_dly_q;
      ack_hit  = ack_valid ? (WIDTH'(1) << ack_id) : '0;
      pend_d   = rise | (pend_q & ~ack_hit);
      // an ack coinciding with a new edge consumes the old event, so nothing is lost
      ovf_d    = (ovf_clear ? '0 : ovf_q) | (rise & pend_q & ~ack_hit);
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = s2_q[i];
            else cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         pend_q       <= '0;
         ovf_q        <= '0;
         cnt_q        <= '{default: '0};
      end else begin
         s1_q         <= raw_in;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         pend_q       <= pend_d;
         ovf_q        <= ovf_d;
         cnt_q        <= cnt_d;
      end
   end

   assign irq_out    = pend_q;
   assign stable_out = stable_q;
   assign overflow   = ovf_q;
endmodule
